fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction prefetch unit that replaces the fixed FETCH / FETCH_IMM / FETCH_IMEM byte-stepping in the multi-cycle core.
- Streams aligned memory words into a byte FIFO and presents a little-endian window of upcoming instruction bytes with its PC.
- The decoder consumes variable-length instructions of 1..WIN_BYTES bytes per cycle.
- Jumps redirect the queue; any in-flight fetch is discarded.

Parameters:
ADDR_W, 32, address width
WORD_BYTES, 4, bytes per memory word; power of 2
BUF_BYTES, 16, FIFO capacity in bytes; power of 2, >= 2*WORD_BYTES
WIN_BYTES, 8, bytes presented to decoder; <= BUF_BYTES
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new PC, any byte alignment
mem_req  out  1  fetch request
mem_addr  out  ADDR_W  word-aligned fetch address
mem_ready  in  1  request accepted when mem_req & mem_ready
mem_rvalid  in  1  read data valid, one cycle per accepted request
mem_rdata  in  8*WORD_BYTES  read word, byte 0 in [7:0]
win_data  out  8*WIN_BYTES  byte i = FIFO byte head+i; bytes >= win_count are don't-care
win_count  out  clog2(BUF_BYTES+1)  total valid bytes in FIFO
win_pc  out  ADDR_W  address of win_data byte 0
take  in  1  consume bytes this cycle
take_len  in  clog2(WIN_BYTES+1)  bytes consumed; 0 = no-op
take_err  out  1  one-cycle pulse: illegal take

Behaviour:
- Reset (rst=0, async):
  - mem_req=0, mem_addr=0, win_count=0, win_pc=RESET_PC, win_data=0, take_err=0.
  - Internal state: fetch address=RESET_PC aligned down, skip=RESET_PC mod WORD_BYTES, no outstanding request, drop flag clear.
  - A reset asserted mid-operation abandons any outstanding request. mem_rvalid is ignored whenever nothing is outstanding.
- FSM states:
  - IDLE: nothing outstanding; insufficient space.
  - REQ: mem_req=1.
  - WAIT: one request outstanding.
- Transitions:
  - IDLE->REQ when BUF_BYTES - win_count >= WORD_BYTES (evaluated on registered count); mem_req rises the next cycle.
  - REQ->WAIT on mem_req & mem_ready. mem_addr is stable while in REQ unless a redirect occurs.
  - WAIT->REQ or WAIT->IDLE on mem_rvalid, using the same space test on the updated count. Fetch address += WORD_BYTES, wrapping mod 2^ADDR_W.
- At most one request is outstanding.
- Append on mem_rvalid in WAIT with drop clear:
  - Write bytes skip..WORD_BYTES-1 at the FIFO tail, then clear skip.
  - Appended count = WORD_BYTES - skip.
- Consume:
  - On take with 0 < take_len <= min(win_count, WIN_BYTES): head += take_len (FIFO pointers wrap mod BUF_BYTES), win_pc += take_len (wrap mod 2^ADDR_W).
  - On take with take_len > win_count or take_len > WIN_BYTES: no state change; take_err=1 the next cycle.
- Simultaneous take and append in one cycle: win_count_next = win_count - take_len + appended. Overflow is impossible by the space rule.
- Redirect (highest priority):
  - win_count=0, win_pc=redirect_pc, pointers reset, fetch address = redirect_pc aligned down, skip = redirect_pc mod WORD_BYTES.
  - take is ignored that cycle (no take_err).
  - If in WAIT, or if accepted that same cycle: set drop. The next mem_rvalid is discarded, clears drop, and the FSM then goes to REQ for the new address.
  - If in REQ and not accepted: the request is retracted and mem_addr updates next cycle. Only mem_req & mem_ready commits a request.
  - A mem_rvalid coincident with redirect is discarded.
- Redirect and reset never produce take_err.
- Throughput: one word per 2 cycles minimum (REQ, WAIT) with zero-latency memory.

Test Plan:
Params 4/16/8, RESET_PC=0.
1. Release reset; memory ready=1, 1-cycle latency, returns 0x44332211 for addr 0 -> mem_req rises with mem_addr=0; win_count=4, win_data[31:0]=0x44332211, win_pc=0; fetches 0x4, 0x8, 0xC follow; mem_req stays 0 at win_count=16.
2. From full, take_len=3 -> win_pc=3, win_count=13, win_data[7:0]=0x44; no request until count <= 12. Next take_len=1 -> request for 0x10 issues.
3. Redirect to 0x102 while the request for 0x10 is outstanding -> 0x10 data discarded; next mem_addr=0x100; data 0xDDCCBBAA -> win_count=2, win_data[15:0]=0xDDCC, win_pc=0x102.
4. win_count=6, take_len=2 in the same cycle as mem_rvalid -> win_count=8, win_pc advanced by 2, new bytes at positions 4..7.
5. win_count=3, take_len=5 -> take_err pulses 1 cycle; win_count, win_pc unchanged. take_len=0 -> no change, no error.
6. Assert rst while in WAIT, then release; drive a stale mem_rvalid -> outputs at reset values immediately, stale data ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect, memory read port and decoder window.
// master drives the queue (core/memory side), slave is the queue itself.
interface fetch_queue_if #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned BUF_BYTES  = 16,
   parameter int unsigned WIN_BYTES  = 8
);
   logic                             redirect;
   logic [ADDR_W-1:0]                redirect_pc;
   logic                             mem_req;
   logic [ADDR_W-1:0]                mem_addr;
   logic                             mem_ready;
   logic                             mem_rvalid;
   logic [8*WORD_BYTES-1:0]          mem_rdata;
   logic [8*WIN_BYTES-1:0]           win_data;
   logic [$clog2(BUF_BYTES+1)-1:0]   win_count;
   logic [ADDR_W-1:0]                win_pc;
   logic                             take;
   logic [$clog2(WIN_BYTES+1)-1:0]   take_len;
   logic                             take_err;

   modport master (
      output redirect, redirect_pc, mem_ready, mem_rvalid, mem_rdata,
      output take, take_len,
      input  mem_req, mem_addr, win_data, win_count, win_pc, take_err
   );

   modport slave (
      input  redirect, redirect_pc, mem_ready, mem_rvalid, mem_rdata,
      input  take, take_len,
      output mem_req, mem_addr, win_data, win_count, win_pc, take_err
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: word fetches into a byte FIFO, exposing a
// little-endian byte window with its PC to a variable-length decoder.
module fetch_queue #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       WORD_BYTES = 4,
   parameter int unsigned       BUF_BYTES  = 16,
   parameter int unsigned       WIN_BYTES  = 8,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input logic          clk,
   input logic          rst,
   fetch_queue_if.slave bus
);
   localparam int PTR_W = $clog2(BUF_BYTES);
   localparam int CNT_W = $clog2(BUF_BYTES + 1);
   localparam int SKP_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(BUF_BYTES - WORD_BYTES);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e            state_q, state_d;
   logic [7:0]        buf_q [BUF_BYTES];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_q, pc_d, fa_q, fa_d;
   logic [SKP_W-1:0]  skip_q, skip_d;
   logic              drop_q, drop_d, err_q, err_d;
   logic              accept, rvld, app, take_ok, take_ovr;
   logic [CNT_W-1:0]  tlen, alen;

   function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(WORD_BYTES - 1);
   endfunction

   function automatic logic [SKP_W-1:0] skp(input logic [ADDR_W-1:0] a);
      return SKP_W'(a & ADDR_W'(WORD_BYTES - 1));
   endfunction

   always_comb begin
      accept   = (state_q == REQ) && bus.mem_ready;
      rvld     = (state_q == WAIT) && bus.mem_rvalid;
      app      = rvld && !drop_q && !bus.redirect;
      tlen     = CNT_W'(bus.take_len);
      alen     = app ? CNT_W'(WORD_BYTES) - CNT_W'(skip_q) : '0;
      take_ovr = (tlen > cnt_q) || (tlen > CNT_W'(WIN_BYTES));
      take_ok  = bus.take && !bus.redirect && (tlen != '0) && !take_ovr;
      err_d    = bus.take && !bus.redirect && take_ovr;

      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      pc_d    = pc_q;
      fa_d    = fa_q;
      skip_d  = skip_q;
      drop_d  = drop_q;

      if (take_ok) begin
         head_d = head_q + PTR_W'(bus.take_len);
         pc_d   = pc_q + ADDR_W'(bus.take_len);
      end
      if (app) begin
         tail_d = tail_q + PTR_W'(alen);
         skip_d = '0;
         fa_d   = fa_q + ADDR_W'(WORD_BYTES);
      end
      cnt_d = cnt_q - (take_ok ? tlen : '0) + alen;

      // An outstanding or just-accepted fetch belongs to the old stream
      if (bus.redirect) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
         pc_d   = bus.redirect_pc;
         fa_d   = align(bus.redirect_pc);
         skip_d = skp(bus.redirect_pc);
         drop_d = ((state_q == WAIT) && !bus.mem_rvalid) || accept;
      end else if (rvld) begin
         drop_d = 1'b0;
      end

      unique case (state_q)
         IDLE:    if (cnt_q <= FILL_MAX) state_d = REQ;
         REQ:     if (accept) state_d = WAIT;
         WAIT:    if (bus.mem_rvalid)
                     state_d = (cnt_d <= FILL_MAX) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         pc_q    <= RESET_PC;
         fa_q    <= align(RESET_PC);
         skip_q  <= skp(RESET_PC);
         drop_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         fa_q    <= fa_d;
         skip_q  <= skip_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
      end else if (app) begin
         for (int j = 0; j < WORD_BYTES; j++)
            if (SKP_W'(j) >= skip_q)
               buf_q[tail_q + PTR_W'(j) - PTR_W'(skip_q)] <=
                  bus.mem_rdata[8*j +: 8];
      end
   end

   always_comb begin
      bus.win_data = '0;
      for (int i = 0; i < WIN_BYTES; i++)
         if (CNT_W'(i) < cnt_q)
            bus.win_data[8*i +: 8] = buf_q[head_q + PTR_W'(i)];
   end

   assign bus.mem_req   = (state_q == REQ);
   assign bus.mem_addr  = (state_q == REQ) ? fa_q : '0;
   assign bus.win_count = cnt_q;
   assign bus.win_pc    = pc_q;
   assign bus.take_err  = err_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic against
// a byte-queue reference model with a latency-randomised memory.
module tb_fetch_queue;
   localparam int AW = 32;
   localparam int WB = 4;
   localparam int BB = 16;
   localparam int WN = 8;
   localparam int TW = $clog2(WN + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fetch_queue_if #(
      .ADDR_W(AW), .WORD_BYTES(WB), .BUF_BYTES(BB), .WIN_BYTES(WN)
   ) bus ();

   fetch_queue #(
      .ADDR_W(AW), .WORD_BYTES(WB), .BUF_BYTES(BB), .WIN_BYTES(WN),
      .RESET_PC('0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [7:0]  q[$];
   logic [31:0] m_pc, m_fa, rv_addr;
   int          m_skip, rv_wait;
   bit          m_out, m_drop, m_req, m_err;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (a == 32'h100) return 32'hDDCC_BBAA;
      for (int j = 0; j < WB; j++) w[8*j +: 8] = 8'((a + 32'(j) + 1) * 17);
      return w;
   endfunction

   task automatic model_reset();
      q.delete();
      m_pc = '0; m_fa = '0; m_skip = 0;
      m_out = 0; m_drop = 0; m_req = 0; m_err = 0;
      rv_wait = 0; rv_addr = '0;
   endtask

   task automatic check_reset();
      chk("rst_req", 64'(bus.mem_req), 64'd0);
      chk("rst_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_count", 64'(bus.win_count), 64'd0);
      chk("rst_pc", 64'(bus.win_pc), 64'd0);
      chk("rst_data", 64'(bus.win_data), 64'd0);
      chk("rst_err", 64'(bus.take_err), 64'd0);
   endtask

   task automatic check_outs();
      logic [63:0] exp, mask;
      exp = '0; mask = '0;
      for (int i = 0; i < WN; i++)
         if (i < q.size()) begin
            exp[8*i +: 8]  = q[i];
            mask[8*i +: 8] = 8'hFF;
         end
      chk("mem_req", 64'(bus.mem_req), 64'(m_req));
      if (m_req) chk("mem_addr", 64'(bus.mem_addr), 64'(m_fa));
      chk("win_count", 64'(bus.win_count), 64'(q.size()));
      chk("win_pc", 64'(bus.win_pc), 64'(m_pc));
      chk("take_err", 64'(bus.take_err), 64'(m_err));
      chk("win_data", 64'(bus.win_data) & mask, exp);
   endtask

   task automatic step(input bit tk, input int tl, input bit rd,
                       input logic [31:0] rpc, input bit rdy,
                       input bit stale, input int lat);
      bit rv, acc, ended;
      logic [31:0] dat;
      int cnt_t;
      rv = 0; dat = '0;
      if (m_out && rv_wait == 0) begin
         rv = 1; dat = mem_word(rv_addr);
      end else if (!m_out && stale) begin
         rv = 1; dat = $urandom;
      end
      bus.take = tk;          bus.take_len = TW'(tl);
      bus.redirect = rd;      bus.redirect_pc = rpc;
      bus.mem_ready = rdy;    bus.mem_rvalid = rv;
      bus.mem_rdata = dat;

      acc   = m_req && rdy;
      ended = m_out && rv;
      cnt_t = q.size();
      if (acc) begin
         rv_addr = m_fa; rv_wait = lat;
      end else if (m_out && !rv) begin
         rv_wait--;
      end
      if (rd) begin
         q.delete();
         m_pc   = rpc;
         m_fa   = rpc & ~32'(WB - 1);
         m_skip = int'(rpc % WB);
         m_drop = (m_out && !rv) || acc;
         m_err  = 0;
      end else begin
         m_err = tk && (tl > q.size() || tl > WN);
         if (tk && tl != 0 && !m_err) begin
            repeat (tl) void'(q.pop_front());
            m_pc += 32'(tl);
         end
         if (ended) begin
            if (m_drop) m_drop = 0;
            else begin
               for (int j = m_skip; j < WB; j++) q.push_back(dat[8*j +: 8]);
               m_skip = 0;
               m_fa  += WB;
            end
         end
      end
      if (m_req)       m_req = !acc;
      else if (!m_out) m_req = cnt_t <= BB - WB;
      else             m_req = ended && q.size() <= BB - WB;
      m_out = (m_out && !rv) || acc;

      @(posedge clk);
      @(negedge clk);
      check_outs();
   endtask

   initial begin
      bus.take = 0; bus.take_len = '0; bus.redirect = 0;
      bus.redirect_pc = '0; bus.mem_ready = 0; bus.mem_rvalid = 0;
      bus.mem_rdata = '0;
      model_reset();
      #12;
      check_reset();
      @(negedge clk);
      rst = 1'b1;
      check_outs();

      // 1: fill from reset PC until the FIFO is full
      repeat (12) step(0, 0, 0, '0, 1, 0, 0);
      chk("t1_count", 64'(bus.win_count), 64'd16);
      chk("t1_word0", 64'(bus.win_data[31:0]), 64'h4433_2211);
      chk("t1_noreq", 64'(bus.mem_req), 64'd0);

      // 2: consume, request resumes only at count 12
      step(1, 3, 0, '0, 1, 0, 0);
      chk("t2_pc", 64'(bus.win_pc), 64'd3);
      chk("t2_count", 64'(bus.win_count), 64'd13);
      chk("t2_byte0", 64'(bus.win_data[7:0]), 64'h44);
      repeat (2) step(0, 0, 0, '0, 0, 0, 0);
      step(1, 1, 0, '0, 0, 0, 0);
      step(0, 0, 0, '0, 0, 0, 0);
      chk("t2_req", 64'(bus.mem_req), 64'd1);
      chk("t2_addr", 64'(bus.mem_addr), 64'h10);

      // 3: redirect with the 0x10 fetch outstanding
      step(0, 0, 0, '0, 1, 0, 1);
      step(0, 0, 1, 32'h102, 0, 0, 0);
      step(0, 0, 0, '0, 0, 0, 0);
      chk("t3_addr", 64'(bus.mem_addr), 64'h100);
      step(0, 0, 0, '0, 1, 0, 0);
      step(0, 0, 0, '0, 0, 0, 0);
      chk("t3_count", 64'(bus.win_count), 64'd2);
      chk("t3_data", 64'(bus.win_data[15:0]), 64'hDDCC);
      chk("t3_pc", 64'(bus.win_pc), 64'h102);

      // 4: take coincident with a returning word
      step(0, 0, 0, '0, 1, 0, 0);
      step(0, 0, 0, '0, 0, 0, 0);
      step(0, 0, 0, '0, 1, 0, 0);
      chk("t4_pre", 64'(bus.win_count), 64'd6);
      step(1, 2, 0, '0, 0, 0, 0);
      chk("t4_count", 64'(bus.win_count), 64'd8);
      chk("t4_pc", 64'(bus.win_pc), 64'h104);
      chk("t4_new", 64'(bus.win_data[63:32]), 64'(mem_word(32'h108)));

      // 5: illegal take and zero-length take
      step(0, 0, 1, 32'h201, 0, 0, 0);
      chk("t5_addr", 64'(bus.mem_addr), 64'h200);
      step(0, 0, 0, '0, 1, 0, 0);
      step(0, 0, 0, '0, 0, 0, 0);
      step(1, 5, 0, '0, 0, 0, 0);
      chk("t5_err", 64'(bus.take_err), 64'd1);
      chk("t5_count", 64'(bus.win_count), 64'd3);
      chk("t5_pc", 64'(bus.win_pc), 64'h201);
      step(1, 0, 0, '0, 0, 0, 0);
      chk("t5_err_off", 64'(bus.take_err), 64'd0);
      chk("t5_count0", 64'(bus.win_count), 64'd3);

      // 6: reset while waiting, stale return ignored
      step(0, 0, 0, '0, 1, 0, 2);
      #2 rst = 1'b0;
      #1 check_reset();
      model_reset();
      bus.take = 0; bus.redirect = 0; bus.mem_ready = 1;
      bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.mem_rvalid = 0;
      check_outs();
      step(0, 0, 0, '0, 0, 1, 0);
      chk("t6_req", 64'(bus.mem_req), 64'd1);
      chk("t6_addr", 64'(bus.mem_addr), 64'd0);
      step(0, 0, 0, '0, 1, 1, 0);
      step(0, 0, 0, '0, 0, 1, 0);
      chk("t6_word", 64'(bus.win_data[31:0]), 64'h4433_2211);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] rpc;
         rpc = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                   : $urandom;
         step($urandom % 2 == 0, $urandom_range(0, 10),
              $urandom % 30 == 0, rpc, $urandom % 3 != 0,
              $urandom % 6 == 0, $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
